// File: rtl/uart_fifo_pkg.sv
// Shared definitions for the UART receive and transmit FIFOs.
package uart_fifo_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned DEPTH_DEF  = 16;

  // Entry layout at the default width: {frame_err, data}.
  localparam int unsigned FERR_BIT   = DATA_W_DEF;

  // Ceiling log2 for sizing address fields; clog2(1) is 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned v;
    int unsigned res;
    v   = (value > 0) ? value - 1 : 0;
    res = 0;
    while (v > 0) begin
      res = res + 1;
      v   = v >> 1;
    end
    return res;
  endfunction

  // Frame-error bit position for a given data width.
  function automatic int unsigned ferr_pos(input int unsigned data_w);
    return data_w;
  endfunction

endpackage

// File: rtl/fifo_rx_mem.sv
// Register-array storage for the receive FIFO: one synchronous write
// port, one asynchronous read port, no reset.
module fifo_rx_mem #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic             clk_fifo_rx,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write the addressed entry on a push.
  always_ff @(posedge clk_fifo_rx) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fifo_rx.sv
// Receive-side FIFO: buffers bytes from the UART receiver with their
// framing-error flag and hands them to the host over valid/ready.
// Bytes arriving while full (and not popped) are dropped and latched
// in a sticky overflow flag.
module fifo_rx
  import uart_fifo_pkg::*;
#(
  parameter  int unsigned DATA_W    = DATA_W_DEF,
  parameter  int unsigned DEPTH     = DEPTH_DEF,
  parameter  int unsigned AFULL_LVL = 12,
  localparam int unsigned PTR_W     = clog2(DEPTH)
) (
  input  logic              clk_fifo_rx,
  input  logic              rst_fifo_rx_n,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_done,
  input  logic              rx_frame_err,
  input  logic              out_ready,
  input  logic              ovf_clr,
  output logic [DATA_W-1:0] data_out,
  output logic              frame_err_out,
  output logic              out_valid,
  output logic              fifo_rx_full,
  output logic              fifo_rx_empty,
  output logic              fifo_rx_afull,
  output logic [PTR_W:0]    count,
  output logic              overflow
);

  localparam int unsigned ENTRY_W = DATA_W + 1;
  localparam int unsigned ERR_BIT = ferr_pos(DATA_W);

  logic [PTR_W:0]   wr_pt;
  logic [PTR_W:0]   rd_pt;
  logic [PTR_W:0]   level;
  logic             empty_i;
  logic             full_i;
  logic             pop;
  logic             push;
  logic             drop;
  logic             ovf_q;
  logic [ENTRY_W-1:0] wr_word;
  logic [ENTRY_W-1:0] rd_word;

  // Occupancy and flags from the registered pointers; the MSB is the wrap bit.
  assign level   = wr_pt - rd_pt;
  assign empty_i = (wr_pt == rd_pt);
  assign full_i  = (wr_pt[PTR_W-1:0] == rd_pt[PTR_W-1:0]) &&
                   (wr_pt[PTR_W] != rd_pt[PTR_W]);

  // Handshake decode; a pop frees a slot so a push into a full FIFO succeeds.
  assign pop  = !empty_i && out_ready;
  assign push = rx_done && (!full_i || pop);
  assign drop = rx_done && full_i && !pop;

  assign wr_word = {rx_frame_err, rx_data};

  fifo_rx_mem #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH),
    .AW    (PTR_W)
  ) u_mem (
    .clk_fifo_rx (clk_fifo_rx),
    .wr_en       (push),
    .wr_addr     (wr_pt[PTR_W-1:0]),
    .wr_data     (wr_word),
    .rd_addr     (rd_pt[PTR_W-1:0]),
    .rd_data     (rd_word)
  );

  // Write pointer advances on every accepted byte.
  always_ff @(posedge clk_fifo_rx or negedge rst_fifo_rx_n) begin
    if (!rst_fifo_rx_n) begin
      wr_pt <= '0;
    end else if (push) begin
      wr_pt <= wr_pt + (PTR_W+1)'(1);
    end
  end

  // Read pointer advances on every consumed byte.
  always_ff @(posedge clk_fifo_rx or negedge rst_fifo_rx_n) begin
    if (!rst_fifo_rx_n) begin
      rd_pt <= '0;
    end else if (pop) begin
      rd_pt <= rd_pt + (PTR_W+1)'(1);
    end
  end

  // Sticky overflow; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk_fifo_rx or negedge rst_fifo_rx_n) begin
    if (!rst_fifo_rx_n) begin
      ovf_q <= 1'b0;
    end else if (drop) begin
      ovf_q <= 1'b1;
    end else if (ovf_clr) begin
      ovf_q <= 1'b0;
    end
  end

  // Head entry is gated to zero while empty so stale storage never leaks.
  assign data_out      = empty_i ? '0   : rd_word[DATA_W-1:0];
  assign frame_err_out = empty_i ? 1'b0 : rd_word[ERR_BIT];

  assign out_valid     = !empty_i;
  assign fifo_rx_empty = empty_i;
  assign fifo_rx_full  = full_i;
  assign fifo_rx_afull = (level >= (PTR_W+1)'(AFULL_LVL));
  assign count         = level;
  assign overflow      = ovf_q;

endmodule
